// File: rtl/rrat_pkg.sv
// rrat_pkg: shared types and sizes for the retirement register alias table
package rrat_pkg;
  localparam int NUM_ARCH_REGS = 32;
  localparam int PHYS_W = 6;
  typedef logic [PHYS_W-1:0] physicalIndexing;
  typedef logic [4:0] arch_idx_t;
  typedef enum logic {IDLE, RECOVER} rrat_state_t;
endpackage

// File: rtl/rrat_if.sv
// rrat_if: ROB commit / free-list / front-end restore signals of the RRAT
// commit_valid/ready/rd/pd and flush_in come from the ROB; free_enqueue/wdata go to the
// free list; restore_valid/map go to the front-end RAT; commit_count is the retire counter.
interface rrat_if;
  import rrat_pkg::*;
  logic commit_valid;
  logic commit_ready;
  arch_idx_t commit_rd;
  physicalIndexing commit_pd;
  logic flush_in;
  logic free_enqueue;
  physicalIndexing free_wdata;
  logic restore_valid;
  logic [NUM_ARCH_REGS*PHYS_W-1:0] restore_map;
  logic [31:0] commit_count;
  modport master (
    output commit_valid, commit_rd, commit_pd, flush_in,
    input commit_ready, free_enqueue, free_wdata, restore_valid, restore_map, commit_count
  );
  modport slave (
    input commit_valid, commit_rd, commit_pd, flush_in,
    output commit_ready, free_enqueue, free_wdata, restore_valid, restore_map, commit_count
  );
endinterface

// File: rtl/rrat.sv
// rrat: committed arch-to-physical map; frees displaced regs and restores the map on flush
// Ports: clk, rst (sync, active-high), bus (rrat_if.slave: commit, free-list and restore signals).
// RRAT_FLUSH_BYPASS_EN: zero-latency restore with same-cycle commit forwarding, no recovery stall.
module rrat import rrat_pkg::*; (
  input logic clk,
  input logic rst,
  rrat_if.slave bus
);
  physicalIndexing tbl [NUM_ARCH_REGS];
  logic accept, wr;
  assign accept = bus.commit_valid && bus.commit_ready;
  // x0 is never renamed, so its commits only count and never touch the table
  assign wr = accept && bus.commit_rd != '0;
`ifdef RRAT_FLUSH_BYPASS_EN
  assign bus.commit_ready = !rst;
  assign bus.restore_valid = bus.flush_in;
  for (genvar i = 0; i < NUM_ARCH_REGS; i++) begin : g_map
    assign bus.restore_map[i*PHYS_W +: PHYS_W] =
      (wr && bus.commit_rd == arch_idx_t'(i)) ? bus.commit_pd : tbl[i];
  end
`else
  rrat_state_t state, state_next;
  always_ff @(posedge clk) state <= rst ? IDLE : state_next;
  always_comb state_next = (state == IDLE && bus.flush_in) ? RECOVER : IDLE;
  assign bus.commit_ready = !rst && state == IDLE;
  assign bus.restore_valid = state == RECOVER;
  for (genvar i = 0; i < NUM_ARCH_REGS; i++) begin : g_map
    assign bus.restore_map[i*PHYS_W +: PHYS_W] = tbl[i];
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) tbl[i] <= physicalIndexing'(i);
      bus.free_enqueue <= 1'b0;
      bus.free_wdata <= '0;
      bus.commit_count <= '0;
    end else begin
      bus.free_enqueue <= wr;
      if (wr) begin
        tbl[bus.commit_rd] <= bus.commit_pd;
        bus.free_wdata <= tbl[bus.commit_rd];
      end
      if (accept) bus.commit_count <= bus.commit_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_rrat.sv
// tb_rrat: randomized scoreboard bench for rrat against a behavioural map model
module tb_rrat;
  typedef struct packed {
    logic ready;
    logic enq;
    logic [5:0] wdata;
    logic [31:0] cnt;
    logic rv;
    logic [191:0] map;
  } exp_t;

  logic clk, rst;
  rrat_if bus();
  rrat dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t q[$];
  exp_t mon_e;
  int checks, errors;
  bit armed;
  bit [5:0] tbl_m [32];
  bit enq_m, recover_m;
  bit [5:0] wd_m;
  bit [31:0] cnt_m;

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [191:0] got, input logic [191:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("commit_ready", 192'(bus.commit_ready), 192'(mon_e.ready));
      chk("free_enqueue", 192'(bus.free_enqueue), 192'(mon_e.enq));
      chk("free_wdata", 192'(bus.free_wdata), 192'(mon_e.wdata));
      chk("commit_count", 192'(bus.commit_count), 192'(mon_e.cnt));
      chk("restore_valid", 192'(bus.restore_valid), 192'(mon_e.rv));
      chk("restore_map", bus.restore_map, mon_e.map);
    end
  end

  // Predicts what the DUT shows before the coming edge, then advances the model past it.
  task automatic step(input bit v, input int rd, input int pd, input bit fl, input bit r);
    exp_t e;
    bit acc;
    rst = r;
    bus.commit_valid = v;
    bus.commit_rd = 5'(rd);
    bus.commit_pd = 6'(pd);
    bus.flush_in = fl;
`ifdef RRAT_FLUSH_BYPASS_EN
    e.ready = !r;
`else
    e.ready = !r && !recover_m;
`endif
    acc = v && e.ready;
    e.enq = enq_m;
    e.wdata = wd_m;
    e.cnt = cnt_m;
    for (int i = 0; i < 32; i++) e.map[i*6 +: 6] = tbl_m[i];
`ifdef RRAT_FLUSH_BYPASS_EN
    e.rv = fl;
    if (acc && rd != 0) e.map[rd*6 +: 6] = 6'(pd);
`else
    e.rv = recover_m;
`endif
    if (armed) q.push_back(e);
    armed = 1;
    if (r) begin
      for (int i = 0; i < 32; i++) tbl_m[i] = 6'(i);
      enq_m = 0;
      wd_m = 0;
      cnt_m = 0;
      recover_m = 0;
    end else begin
      enq_m = acc && rd != 0;
      if (enq_m) begin
        wd_m = tbl_m[rd];
        tbl_m[rd] = 6'(pd);
      end
      if (acc) cnt_m = cnt_m + 1;
`ifdef RRAT_FLUSH_BYPASS_EN
      recover_m = 0;
`else
      recover_m = fl && !recover_m;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1;
    rst = 1;
    bus.commit_valid = 0;
    bus.commit_rd = 0;
    bus.commit_pd = 0;
    bus.flush_in = 0;
    checks = 0;
    errors = 0;
    armed = 0;
    for (int i = 0; i < 32; i++) tbl_m[i] = 6'(i);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 5, 40, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 7, 33, 0, 0);
    step(1, 7, 50, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 3, 45, 1, 0);
    step(1, 9, 20, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 4, 44, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 6, 61, 0, 0);
    step(1, 6, 62, 0, 0);
    step(1, 6, 63, 0, 0);
    repeat (3000)
      step($urandom_range(0, 99) < 70, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) == 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 192'(q.size()), 192'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
